branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 102 ++++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predictor : direct-mapped BTB/BHT (2-bit counters), EX resolution |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        bp,
   output logic [31:0] BTB_target,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        flush,
   output logic [31:0] PC_correct,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];
   logic [31:0]      r_br_count;
   logic [31:0]      r_mispred_count;

   logic [IDX_W-1:0] w_if_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic             w_if_hit;
   logic [IDX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0] w_ex_tag;
   logic             w_ex_hit;
   logic             w_br_event;
   logic             w_mispredict;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_if_tag = if_pc[31:IDX_W+2];
   assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

   assign w_ex_idx = ex_pc[IDX_W+1:2];
   assign w_ex_tag = ex_pc[31:IDX_W+2];
   assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

   assign w_br_event   = ex_valid && ex_is_branch;
   assign w_mispredict = w_br_event &&
                         ((ex_pred_taken != ex_taken) ||
                          (ex_taken && ex_pred_taken && (ex_pred_target != ex_target)));

   // Lookup reads the registered table, so a same-cycle EX write is seen next cycle.
   assign bp         = rst && w_if_hit && r_ctr[w_if_idx][1];
   assign BTB_target = w_if_hit ? r_target[w_if_idx] : (if_pc + 32'd4);

   assign flush      = rst && w_mispredict;
   assign PC_correct = ex_taken ? ex_target : (ex_pc + 32'd4);

   assign br_count      = r_br_count;
   assign mispred_count = r_mispred_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= 2'b01;
         end
         r_br_count      <= 32'd0;
         r_mispred_count <= 32'd0;
      end else if (w_br_event) begin
         r_br_count <= r_br_count + 32'd1;
         if (w_mispredict) begin
            r_mispred_count <= r_mispred_count + 32'd1;
         end
         if (w_ex_hit) begin
            if (ex_taken) begin
               r_target[w_ex_idx] <= ex_target;
               if (r_ctr[w_ex_idx] != 2'b11) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
               end
            end else if (r_ctr[w_ex_idx] != 2'b00) begin
               r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
            end
         end else if (ex_taken) begin
            // Taken miss replaces whatever occupied the slot, starting weakly taken.
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= ex_target;
            r_ctr[w_ex_idx]    <= 2'b10;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_predictor : directed vector bench for branch_predictor         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_branch_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        bp;
   logic [31:0] BTB_target;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        flush;
   logic [31:0] PC_correct;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   int checks = 0;
   int errors = 0;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_pc          (if_pc),
      .bp             (bp),
      .BTB_target     (BTB_target),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_pc          (ex_pc),
      .ex_taken       (ex_taken),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .flush          (flush),
      .PC_correct     (PC_correct),
      .br_count       (br_count),
      .mispred_count  (mispred_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] if_pc;
      logic        ex_valid;
      logic        ex_is_branch;
      logic [31:0] ex_pc;
      logic        ex_taken;
      logic [31:0] ex_target;
      logic        ex_pred_taken;
      logic [31:0] ex_pred_target;
      logic        bp;
      logic [31:0] btb;
      logic        chk_btb;
      logic        flush;
      logic [31:0] pcc;
      logic        chk_pcc;
      logic [31:0] brc;
      logic [31:0] mis;
      logic        chk_cnt;
   } vec_t;

   // Cycle with no EX instruction.
   function automatic vec_t nb(input logic [31:0] pc, input logic e_bp, input logic [31:0] e_btb,
                               input logic [31:0] e_brc, input logic [31:0] e_mis);
      vec_t v;
      v = '{rst: 1'b1, if_pc: pc, ex_valid: 1'b0, ex_is_branch: 1'b0, ex_pc: 32'h0,
            ex_taken: 1'b0, ex_target: 32'h0, ex_pred_taken: 1'b0, ex_pred_target: 32'h0,
            bp: e_bp, btb: e_btb, chk_btb: 1'b1, flush: 1'b0, pcc: 32'h0, chk_pcc: 1'b0,
            brc: e_brc, mis: e_mis, chk_cnt: 1'b1};
      return v;
   endfunction

   // Cycle with a valid EX branch.
   function automatic vec_t br(input logic [31:0] pc, input logic [31:0] xpc, input logic tk,
                               input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                               input logic e_bp, input logic [31:0] e_btb, input logic e_fl,
                               input logic [31:0] e_pcc, input logic [31:0] e_brc,
                               input logic [31:0] e_mis);
      vec_t v;
      v = '{rst: 1'b1, if_pc: pc, ex_valid: 1'b1, ex_is_branch: 1'b1, ex_pc: xpc,
            ex_taken: tk, ex_target: tgt, ex_pred_taken: ptk, ex_pred_target: ptgt,
            bp: e_bp, btb: e_btb, chk_btb: 1'b1, flush: e_fl, pcc: e_pcc, chk_pcc: 1'b1,
            brc: e_brc, mis: e_mis, chk_cnt: 1'b1};
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int row);
      @(negedge clk);
      rst            = v.rst;
      if_pc          = v.if_pc;
      ex_valid       = v.ex_valid;
      ex_is_branch   = v.ex_is_branch;
      ex_pc          = v.ex_pc;
      ex_taken       = v.ex_taken;
      ex_target      = v.ex_target;
      ex_pred_taken  = v.ex_pred_taken;
      ex_pred_target = v.ex_pred_target;
      #3;
      chk("bp", row, {31'd0, bp}, {31'd0, v.bp});
      chk("flush", row, {31'd0, flush}, {31'd0, v.flush});
      if (v.chk_btb) chk("BTB_target", row, BTB_target, v.btb);
      if (v.chk_pcc) chk("PC_correct", row, PC_correct, v.pcc);
      if (v.chk_cnt) begin
         chk("br_count", row, br_count, v.brc);
         chk("mispred_count", row, mispred_count, v.mis);
      end
   endtask

   vec_t tbl [23];
   vec_t v;

   initial begin
      rst = 1'b0; if_pc = 32'h0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0;
      ex_taken = 1'b0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;

      // Cold miss, allocation, hit.
      tbl[0]  = nb(32'h100, 1'b0, 32'h104, 0, 0);
      tbl[1]  = br(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h200, 0, 0);
      tbl[2]  = nb(32'h100, 1'b1, 32'h200, 1, 1);
      // Saturate to 3, then two not-taken resolutions.
      tbl[3]  = br(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200, 1, 1);
      tbl[4]  = br(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200, 2, 1);
      tbl[5]  = br(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200, 3, 1);
      tbl[6]  = br(32'h100, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104, 4, 1);
      tbl[7]  = nb(32'h100, 1'b1, 32'h200, 5, 2);
      tbl[8]  = br(32'h100, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104, 5, 2);
      tbl[9]  = nb(32'h100, 1'b0, 32'h200, 6, 3);
      // Retrain, then target mispredict 0x200 -> 0x300.
      tbl[10] = br(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h200, 1'b0, 32'h200, 1'b1, 32'h200, 6, 3);
      tbl[11] = br(32'h100, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 7, 4);
      tbl[12] = nb(32'h100, 1'b1, 32'h300, 8, 5);
      // Alias: 0x140 shares index 0 with 0x100.
      tbl[13] = br(32'h100, 32'h140, 1'b1, 32'h400, 1'b0, 32'h144, 1'b1, 32'h300, 1'b1, 32'h400, 8, 5);
      tbl[14] = nb(32'h100, 1'b0, 32'h104, 9, 6);
      tbl[15] = nb(32'h140, 1'b1, 32'h400, 9, 6);
      // Non-branch and invalid EX with otherwise mispredicting fields.
      tbl[16] = nb(32'h140, 1'b1, 32'h400, 9, 6);
      tbl[16].ex_valid = 1'b1; tbl[16].ex_pc = 32'h140; tbl[16].ex_pred_taken = 1'b1;
      tbl[17] = nb(32'h140, 1'b1, 32'h400, 9, 6);
      tbl[17].ex_is_branch = 1'b1; tbl[17].ex_pc = 32'h140; tbl[17].ex_pred_taken = 1'b1;
      tbl[18] = nb(32'h140, 1'b1, 32'h400, 9, 6);
      // Not-taken miss leaves the table alone; wrap of PC+4.
      tbl[19] = br(32'h200, 32'h200, 1'b0, 32'h0, 1'b0, 32'h204, 1'b0, 32'h204, 1'b0, 32'h204, 9, 6);
      tbl[20] = nb(32'h200, 1'b0, 32'h204, 10, 6);
      tbl[21] = br(32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 10, 6);
      tbl[22] = nb(32'h140, 1'b1, 32'h400, 11, 6);

      // Initial reset, with mispredicting EX inputs held to prove flush stays low.
      for (int i = 0; i < 2; i++) begin
         v = br(32'h100, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0);
         v.rst = 1'b0; v.chk_btb = 1'b0; v.chk_pcc = 1'b0; v.chk_cnt = 1'b0;
         run_vec(v, 100 + i);
      end

      for (int i = 0; i < 23; i++) run_vec(tbl[i], i);

      // Reset mid-stream: reset, 5 branches / 2 mispredicts, 1-cycle reset.
      v = br(32'h140, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 11, 6);
      v.rst = 1'b0; v.chk_btb = 1'b0; v.chk_pcc = 1'b0;
      run_vec(v, 200);
      run_vec(br(32'h140, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0, 32'h144, 1'b1, 32'h200, 0, 0), 201);
      run_vec(br(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200, 1, 1), 202);
      run_vec(br(32'h100, 32'h180, 1'b0, 32'h0, 1'b0, 32'h184, 1'b1, 32'h200, 1'b0, 32'h184, 2, 1), 203);
      run_vec(br(32'h100, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h104, 3, 1), 204);
      run_vec(br(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200, 4, 2), 205);
      v = br(32'h100, 32'h100, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 5, 2);
      v.rst = 1'b0; v.chk_btb = 1'b0; v.chk_pcc = 1'b0;
      run_vec(v, 206);
      run_vec(nb(32'h100, 1'b0, 32'h104, 0, 0), 207);
      run_vec(nb(32'h140, 1'b0, 32'h144, 0, 0), 208);

      // Same-cycle read/write at index 0.
      run_vec(br(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h200, 0, 0), 300);
      run_vec(nb(32'h100, 1'b1, 32'h200, 1, 1), 301);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
